// File: rtl/acam_pkg.sv
// acam_pkg: constants and types shared by the acoustic-camera sample read path.
package acam_pkg;
    localparam int ADDR_W        = 9;
    localparam int DATA_W        = 16;
    localparam int LEN_W         = 10;
    localparam int MIC_FRAME_LEN = 512;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;
endpackage

// File: rtl/ram_frame_reader_if.sv
// ram_frame_reader_if: control, RAM port-B and output-stream signals of the frame reader.
interface ram_frame_reader_if;
    import acam_pkg::*;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] adb;
    logic              ceb;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output start, base_addr, len, ram_dout, m_ready,
        input  busy, done, adb, ceb, m_data, m_valid, m_last
    );
    modport slave (
        input  start, base_addr, len, ram_dout, m_ready,
        output busy, done, adb, ceb, m_data, m_valid, m_last
    );
endinterface

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry FIFO of {last, data} beats that absorbs RAM read data under backpressure.
module skid_buf2
    import acam_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       pop_i,
    input  beat_t      din_i,
    output logic [1:0] count_o,
    output beat_t      head_o
);
    beat_t      mem_q [2];
    logic       wr_q, rd_q;
    logic [1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wr_q    <= wr_q ^ push_i;
            rd_q    <= rd_q ^ pop_i;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/ram_frame_reader.sv
// ram_frame_reader: streams LEN samples from a circular base address of a 512x16 sample RAM
// onto a valid/ready stream, hiding the 1-cycle RAM read latency.
module ram_frame_reader
    import acam_pkg::*;
(
    input logic               clk,
    input logic               reset,
    ram_frame_reader_if.slave bus
);
    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, adb_q;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              inflight_q, last_q, done_q, done_d;
    logic              issue, hs, push, pop, valid;
    logic [1:0]        count, credit;
    beat_t             fifo_head, head, rd_beat;

    assign rd_beat = {last_q, bus.ram_dout};

    skid_buf2 u_skid (
        .clk    (clk),
        .rst    (reset),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (rd_beat),
        .count_o(count),
        .head_o (fifo_head)
    );

    // Every issued read owns a buffer slot until its beat handshakes.
    assign credit = 2'd2 - count - {1'b0, inflight_q};

    always_comb begin
        issue       = state_q == RUN && remaining_q != '0 && credit != '0;
        valid       = count != '0 || inflight_q;
        head        = count != '0 ? fifo_head : inflight_q ? rd_beat : '0;
        hs          = valid && bus.m_ready;
        pop         = hs && count != '0;
        // An empty buffer lets fresh RAM data go straight out when the sink is ready.
        push        = inflight_q && !(count == '0 && bus.m_ready);
        done_d      = state_q == DRAIN && hs && head.last;
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        if (state_q == IDLE && bus.start) begin
            state_d     = RUN;
            rd_ptr_d    = bus.base_addr;
            remaining_d = bus.len == '0 ? LEN_W'(MIC_FRAME_LEN) : bus.len;
        end
        if (issue) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            state_d     = remaining_q == LEN_W'(1) ? DRAIN : RUN;
        end
        if (done_d) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            adb_q       <= '0;
            inflight_q  <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            adb_q       <= issue ? rd_ptr_q : adb_q;
            inflight_q  <= issue;
            last_q      <= issue && remaining_q == LEN_W'(1);
            done_q      <= done_d;
        end
    end

    assign bus.busy    = state_q != IDLE;
    assign bus.done    = done_q;
    assign bus.ceb     = issue;
    assign bus.adb     = issue ? rd_ptr_q : adb_q;
    assign bus.m_valid = valid;
    assign bus.m_data  = head.data;
    assign bus.m_last  = head.last;
endmodule

// File: tb/tb_ram_frame_reader.sv
// tb_ram_frame_reader: directed frames against a preloaded RAM model with a beat/address scoreboard.
module tb_ram_frame_reader;
    import acam_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    ram_frame_reader_if bus ();

    ram_frame_reader dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    beat_t             sb [$];
    logic [ADDR_W-1:0] adbq [$];
    beat_t             e;
    logic [DATA_W-1:0] pd;
    int checks = 0, errors = 0, cyc = 0, outst = 0, beats = 0, done_cnt = 0;
    int done_cyc = -1, last_hs_cyc = -1, fv_cyc = -1, s_cyc = 0;
    bit fv_seen = 0, rand_mode = 0, pv = 0, pr = 0, pl = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bus.ceb) bus.ram_dout <= mem[bus.adb];

    always @(posedge clk) begin
        #1;
        bus.m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            outst = 0;
            pv    = 0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", 32'(bus.m_valid), 1);
                chk("hold_data", 32'(bus.m_data), 32'(pd));
                chk("hold_last", 32'(bus.m_last), 32'(pl));
            end
            if (bus.ceb) begin
                chk("credit", 32'(outst < 2), 1);
                chk("adb_pending", 32'(adbq.size() != 0), 1);
                if (adbq.size() != 0) chk("adb", 32'(bus.adb), 32'(adbq.pop_front()));
            end
            if (bus.m_valid && !fv_seen) begin
                fv_seen = 1;
                fv_cyc  = cyc;
            end
            if (bus.m_valid && bus.m_ready) begin
                chk("sb_pending", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat_data", 32'(bus.m_data), 32'(e.data));
                    chk("beat_last", 32'(bus.m_last), 32'(e.last));
                end
                beats++;
                if (bus.m_last) last_hs_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            outst = outst + (bus.ceb ? 1 : 0) - ((bus.m_valid && bus.m_ready) ? 1 : 0);
            pv = bus.m_valid;
            pr = bus.m_ready;
            pd = bus.m_data;
            pl = bus.m_last;
        end
    end

    // Caller is just after a rising edge; start is held for exactly one cycle.
    task automatic start_frame(input int base, input int len);
        int n = len == 0 ? MIC_FRAME_LEN : len;
        logic [ADDR_W-1:0] a;
        bus.start     = 1'b1;
        bus.base_addr = ADDR_W'(base);
        bus.len       = LEN_W'(len);
        s_cyc         = cyc;
        fv_seen       = 0;
        for (int i = 0; i < n; i++) begin
            a = ADDR_W'(base + i);
            adbq.push_back(a);
            sb.push_back({i == n - 1, mem[a]});
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int max);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_done_cyc"}, done_cyc, last_hs_cyc + 1);
        chk({tag, "_first_valid"}, fv_cyc, s_cyc + 2);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_adb_empty"}, adbq.size(), 0);
        chk({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int n, b0, d0;
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 16'(i * 1103 + 17) ^ 16'h3C00;
        mem[0]   = 16'hFFFB;
        mem[1]   = 16'hFF46;
        mem[510] = 16'h0000;
        mem[511] = 16'h0000;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ceb", 32'(bus.ceb), 0);
        chk("rst_adb", 32'(bus.adb), 0);
        chk("rst_valid", 32'(bus.m_valid), 0);
        chk("rst_last", 32'(bus.m_last), 0);
        chk("rst_data", 32'(bus.m_data), 0);
        reset = 1'b0;

        // Full 512-sample frame at one beat per clock.
        @(posedge clk); #1;
        start_frame(0, 0);
        wait_frame("t1", 700);
        chk("t1_rate", last_hs_cyc - fv_cyc, 511);

        // Address wrap 510, 511, 0, 1.
        @(posedge clk); #1;
        start_frame(510, 4);
        wait_frame("t2", 50);

        // Random backpressure.
        rand_mode = 1;
        @(posedge clk); #1;
        start_frame(37, 300);
        wait_frame("t3", 3000);
        rand_mode = 0;

        // Single beat; a start pulse while busy must be ignored.
        @(posedge clk); #1;
        start_frame(0, 1);
        bus.start     = 1'b1;
        bus.base_addr = ADDR_W'(100);
        bus.len       = LEN_W'(5);
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_frame("t4", 50);
        chk("t4_done_s3", done_cyc, s_cyc + 3);

        // Reset mid-frame after beat 100.
        @(posedge clk); #1;
        b0 = beats;
        start_frame(0, 0);
        n = 0;
        while (beats - b0 < 100 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_beats", beats - b0, 100);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        chk("t5_valid_low", 32'(bus.m_valid), 0);
        chk("t5_busy_low", 32'(bus.busy), 0);
        chk("t5_ceb_low", 32'(bus.ceb), 0);
        sb.delete();
        adbq.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t5_no_done", done_cnt, d0);
        start_frame(0, 2);
        wait_frame("t5", 50);

        // Back-to-back: second start lands in the done cycle of the first.
        @(posedge clk); #1;
        start_frame(5, 3);
        n = 0;
        while (bus.done !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_done_seen", 32'(bus.done), 1);
        chk("t6_busy_in_done", 32'(bus.busy), 0);
        start_frame(200, 4);
        wait_frame("t6", 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
